// File: rtl/writeback_dual.sv
// Dual-lane writeback stage.
// Takes an older (lane 1) and a younger (lane 2) instruction as a pair and turns them into
// register-file writes. ALU results are written directly. Load results are selected and
// extended from memory read data.
//
// If a load lane has not been acknowledged by memory when the pair is accepted, the pair is
// parked and STALL is raised. The pair then waits until every load lane has its data, so both
// lanes always write in the same cycle. If a load never completes, a wait counter times it
// out: the pending load lanes are dropped and WB_ERR is set.
//
// Ports
//   reloj, reset                  clock, asynchronous active-high reset
//   VALID_i, DEST_i, ALU_i        lane valid, destination register, ALU result
//   MEM_TO_REG_i, LOAD_TYPE_i     result source select, load format
//   BYTE_OFF_i                    byte offset within the loaded word
//   MEM_DATA_i, MEM_ACK_i         memory read data and its valid strobe
//   DI_i, DIR_WRA_i, REG_WR_i     register-file write data, address, active-low enable
//   STALL, WB_ERR                 upstream hold, sticky memory-timeout flag
module writeback_dual (
  input  logic        reloj,
  input  logic        reset,
  input  logic        VALID_1,
  input  logic [4:0]  DEST_1,
  input  logic [31:0] ALU_1,
  input  logic        MEM_TO_REG_1,
  input  logic [2:0]  LOAD_TYPE_1,
  input  logic [1:0]  BYTE_OFF_1,
  input  logic [31:0] MEM_DATA_1,
  input  logic        MEM_ACK_1,
  input  logic        VALID_2,
  input  logic [4:0]  DEST_2,
  input  logic [31:0] ALU_2,
  input  logic        MEM_TO_REG_2,
  input  logic [2:0]  LOAD_TYPE_2,
  input  logic [1:0]  BYTE_OFF_2,
  input  logic [31:0] MEM_DATA_2,
  input  logic        MEM_ACK_2,
  output logic [31:0] DI_1,
  output logic [4:0]  DIR_WRA_1,
  output logic        REG_WR_1,
  output logic [31:0] DI_2,
  output logic [4:0]  DIR_WRA_2,
  output logic        REG_WR_2,
  output logic        STALL,
  output logic        WB_ERR
);

  typedef enum logic [0:0] {StAccept, StWait} state_e;

  typedef struct packed {
    logic        vld;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        m2r;
    logic [2:0]  ltype;
    logic [1:0]  off;
  } lane_t;

  // Wait cycles are counted from 0. The edge that would take the counter to 255 is the
  // timeout edge, so a load that is never acknowledged stalls for exactly 255 cycles.
  localparam logic [7:0] TimeoutCnt = 8'd254;

  // Index 0 is lane 1 (older), index 1 is lane 2 (younger).
  lane_t [1:0]       in_lane;
  logic  [1:0][31:0] mem_data;
  logic  [1:0]       ack;

  assign in_lane[0] = {VALID_1, DEST_1, ALU_1, MEM_TO_REG_1, LOAD_TYPE_1, BYTE_OFF_1};
  assign in_lane[1] = {VALID_2, DEST_2, ALU_2, MEM_TO_REG_2, LOAD_TYPE_2, BYTE_OFF_2};
  assign mem_data   = {MEM_DATA_2, MEM_DATA_1};
  assign ack        = {MEM_ACK_2, MEM_ACK_1};

  state_e            state_q, state_d;
  lane_t [1:0]       pair_q, pair_d;
  logic  [1:0][31:0] data_q, data_d;
  logic  [1:0]       done_q, done_d;
  logic  [7:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              stall_q;
  logic  [1:0][31:0] di_q;
  logic  [1:0][4:0]  wra_q;
  logic  [1:0]       reg_wr_q;

  // Write-side signals for the pair being retired this cycle.
  lane_t [1:0]       sel_pair;
  logic  [1:0][31:0] sel_data;
  logic  [1:0]       keep;
  logic              issue;
  logic  [1:0]       rdy;
  logic  [1:0]       we;
  logic  [1:0][31:0] wd;

  function automatic logic [31:0] load_fmt(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (lt)
      3'b001:  r = {{24{b[7]}}, b};
      3'b010:  r = {24'd0, b};
      3'b011:  r = {{16{h[15]}}, h};
      3'b100:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    data_d   = data_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    sel_pair = in_lane;
    sel_data = mem_data;
    keep     = 2'b11;
    issue    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !in_lane[i].vld || !in_lane[i].m2r || ack[i];
    end

    unique case (state_q)
      StAccept: begin
        if (in_lane[0].vld || in_lane[1].vld) begin
          if (&rdy) begin
            issue = 1'b1;
          end else begin
            // Park the pair together with whatever load data already arrived.
            pair_d = in_lane;
            done_d = rdy;
            for (int i = 0; i < 2; i++) begin
              if (ack[i]) data_d[i] = mem_data[i];
            end
            cnt_d   = 8'd0;
            state_d = StWait;
          end
        end
      end
      default: begin
        for (int i = 0; i < 2; i++) begin
          if (!done_q[i] && ack[i]) begin
            done_d[i] = 1'b1;
            data_d[i] = mem_data[i];
          end
        end
        sel_pair = pair_q;
        sel_data = data_d;
        if (&done_d) begin
          issue   = 1'b1;
          state_d = StAccept;
        end else if (cnt_q == TimeoutCnt) begin
          // Timeout: retire the lanes that have their data, drop the rest.
          issue   = 1'b1;
          keep    = done_d;
          err_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = StAccept;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    for (int i = 0; i < 2; i++) begin
      we[i] = issue && keep[i] && sel_pair[i].vld && (sel_pair[i].dest != 5'd0);
      wd[i] = sel_pair[i].m2r ? load_fmt(sel_pair[i].ltype, sel_pair[i].off, sel_data[i])
                              : sel_pair[i].alu;
    end
    // Same destination in both lanes: the younger result wins.
    if (sel_pair[0].vld && sel_pair[1].vld && (sel_pair[0].dest == sel_pair[1].dest)) begin
      we[0] = 1'b0;
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_q  <= StAccept;
      pair_q   <= '0;
      data_q   <= '0;
      done_q   <= '0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      di_q     <= '0;
      wra_q    <= '0;
      reg_wr_q <= 2'b11;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= (state_d == StWait);
      for (int i = 0; i < 2; i++) begin
        reg_wr_q[i] <= ~we[i];
        // Non-writing lanes hold their last data and address.
        if (we[i]) begin
          di_q[i]  <= wd[i];
          wra_q[i] <= sel_pair[i].dest;
        end
      end
    end
  end

  assign DI_1      = di_q[0];
  assign DI_2      = di_q[1];
  assign DIR_WRA_1 = wra_q[0];
  assign DIR_WRA_2 = wra_q[1];
  assign REG_WR_1  = reg_wr_q[0];
  assign REG_WR_2  = reg_wr_q[1];
  assign STALL     = stall_q;
  assign WB_ERR    = err_q;

endmodule

// File: tb/tb_writeback_dual.sv
// Self-checking bench for writeback_dual: table-driven single-cycle pairs, hand-written
// stall / timeout / reset sequences, and a write scoreboard checked by a monitor.
module tb_writeback_dual;

  logic        reloj = 1'b0;
  logic        reset;
  logic        valid_1, valid_2, m2r_1, m2r_2, ack_1, ack_2;
  logic [4:0]  dest_1, dest_2;
  logic [31:0] alu_1, alu_2, md_1, md_2;
  logic [2:0]  lt_1, lt_2;
  logic [1:0]  off_1, off_2;
  logic [31:0] di_1, di_2;
  logic [4:0]  wra_1, wra_2;
  logic        reg_wr_1, reg_wr_2, stall, wb_err;

  int checks = 0;
  int passed = 0;

  always #5 reloj = ~reloj;

  writeback_dual dut (
    .reloj(reloj), .reset(reset),
    .VALID_1(valid_1), .DEST_1(dest_1), .ALU_1(alu_1), .MEM_TO_REG_1(m2r_1),
    .LOAD_TYPE_1(lt_1), .BYTE_OFF_1(off_1), .MEM_DATA_1(md_1), .MEM_ACK_1(ack_1),
    .VALID_2(valid_2), .DEST_2(dest_2), .ALU_2(alu_2), .MEM_TO_REG_2(m2r_2),
    .LOAD_TYPE_2(lt_2), .BYTE_OFF_2(off_2), .MEM_DATA_2(md_2), .MEM_ACK_2(ack_2),
    .DI_1(di_1), .DIR_WRA_1(wra_1), .REG_WR_1(reg_wr_1),
    .DI_2(di_2), .DIR_WRA_2(wra_2), .REG_WR_2(reg_wr_2),
    .STALL(stall), .WB_ERR(wb_err)
  );

  typedef struct {
    logic v1; logic [4:0] d1; logic [31:0] a1; logic m1; logic [2:0] lt1; logic [1:0] o1;
    logic [31:0] md1; logic ak1;
    logic v2; logic [4:0] d2; logic [31:0] a2; logic m2; logic [2:0] lt2; logic [1:0] o2;
    logic [31:0] md2; logic ak2;
    logic we1; logic we2; logic [31:0] di1; logic [31:0] di2;
  } vec_t;

  typedef struct {
    logic we1; logic we2; logic [31:0] di1; logic [31:0] di2; logic [4:0] wra1; logic [4:0] wra2;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, want);
  endtask

  task automatic push(input logic we1, input logic we2, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    e.we1 = we1; e.we2 = we2; e.di1 = d1; e.di2 = d2; e.wra1 = a1; e.wra2 = a2;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge reloj);
    @(negedge reloj);
  endtask

  task automatic idle_inputs();
    valid_1 = 0; dest_1 = 0; alu_1 = 0; m2r_1 = 0; lt_1 = 0; off_1 = 0; md_1 = 0; ack_1 = 0;
    valid_2 = 0; dest_2 = 0; alu_2 = 0; m2r_2 = 0; lt_2 = 0; off_2 = 0; md_2 = 0; ack_2 = 0;
  endtask

  task automatic apply(input vec_t v);
    valid_1 = v.v1; dest_1 = v.d1; alu_1 = v.a1; m2r_1 = v.m1; lt_1 = v.lt1; off_1 = v.o1;
    md_1 = v.md1; ack_1 = v.ak1;
    valid_2 = v.v2; dest_2 = v.d2; alu_2 = v.a2; m2r_2 = v.m2; lt_2 = v.lt2; off_2 = v.o2;
    md_2 = v.md2; ack_2 = v.ak2;
  endtask

  // Scoreboard monitor: every presented write must match the oldest expected pair.
  always @(negedge reloj) begin
    if (reset === 1'b0 && (reg_wr_1 === 1'b0 || reg_wr_2 === 1'b0)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_write", {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_reg_wr_1", {31'd0, reg_wr_1}, {31'd0, ~e.we1});
        chk("sb_reg_wr_2", {31'd0, reg_wr_2}, {31'd0, ~e.we2});
        if (e.we1) begin
          chk("sb_di_1", di_1, e.di1);
          chk("sb_wra_1", {27'd0, wra_1}, {27'd0, e.wra1});
        end
        if (e.we2) begin
          chk("sb_di_2", di_2, e.di2);
          chk("sb_wra_2", {27'd0, wra_2}, {27'd0, e.wra2});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // v1 d1 a1 m1 lt1 o1 md1 ak1 | v2 d2 a2 m2 lt2 o2 md2 ak2 | we1 we2 di1 di2 (we: 1 = write)
    vecs[0] = '{1, 3, 32'h11, 0, 0, 0, 0, 0,  1, 4, 32'h22, 0, 0, 0, 0, 0,
                1, 1, 32'h11, 32'h22};
    vecs[1] = '{1, 5, 32'hA, 0, 0, 0, 0, 0,  1, 5, 32'hB, 0, 0, 0, 0, 0,
                0, 1, 32'h0, 32'hB};
    vecs[2] = '{1, 0, 32'h55, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'h0, 32'h0};
    vecs[3] = '{1, 6, 0, 1, 3'b000, 0, 32'hDEADBEEF, 1,  1, 7, 32'h77, 0, 0, 0, 0, 0,
                1, 1, 32'hDEADBEEF, 32'h77};
    vecs[4] = '{1, 8, 0, 1, 3'b010, 3, 32'h9A000000, 1,  1, 9, 0, 1, 3'b001, 1, 32'h0000F000, 1,
                1, 1, 32'h0000009A, 32'hFFFFFFF0};
    vecs[5] = '{1, 10, 0, 1, 3'b011, 2, 32'h80011234, 1,
                1, 11, 0, 1, 3'b100, 1, 32'hABCDF00D, 1,
                1, 1, 32'hFFFF8001, 32'h0000F00D};
    vecs[6] = '{1, 12, 0, 1, 3'b111, 3, 32'h12345678, 1,
                1, 13, 0, 1, 3'b011, 3, 32'h7FFF0000, 1,
                1, 1, 32'h12345678, 32'h00007FFF};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 31, 32'hCAFE, 0, 0, 0, 0, 0,
                0, 1, 32'h0, 32'hCAFE};
    // An invalid lane flagged as an unacknowledged load must not stall the pair.
    vecs[9] = '{0, 1, 0, 1, 3'b001, 0, 0, 0,  1, 2, 32'h2, 0, 0, 0, 0, 0,
                0, 1, 32'h0, 32'h2};

    reset = 1'b1;
    idle_inputs();
    @(negedge reloj);
    @(negedge reloj);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_reg_wr", {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
    chk("rst_di", di_1 | di_2, 32'd0);
    chk("rst_wra", {22'd0, wra_1, wra_2}, 32'd0);
    chk("rst_err", {31'd0, wb_err}, 32'd0);
    reset = 1'b0;

    // Table-driven single-cycle pairs.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      if (vecs[i].we1 || vecs[i].we2)
        push(vecs[i].we1, vecs[i].we2, vecs[i].di1, vecs[i].di2, vecs[i].d1, vecs[i].d2);
      step();
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("vec%0d_reg_wr_1", i), {31'd0, reg_wr_1}, {31'd0, ~vecs[i].we1});
      chk($sformatf("vec%0d_reg_wr_2", i), {31'd0, reg_wr_2}, {31'd0, ~vecs[i].we2});
    end
    idle_inputs();
    step();
    chk("idle_reg_wr", {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
    chk("idle_di_hold", di_2, 32'h2);

    // Signed byte load acknowledged after three stall cycles; ALU lane writes with it.
    valid_1 = 1; dest_1 = 14; m2r_1 = 1; lt_1 = 3'b001; off_1 = 2; md_1 = 32'h0; ack_1 = 0;
    valid_2 = 1; dest_2 = 15; alu_2 = 32'h1515;
    push(1, 1, 32'hFFFFFF80, 32'h1515, 14, 15);
    step();
    // Held inputs changed while stalled must be ignored.
    alu_2 = 32'hBAD; dest_2 = 9; dest_1 = 1; lt_1 = 3'b000;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lb_stall_%0d", k), {31'd0, stall}, 32'd1);
      chk($sformatf("lb_nowrite_%0d", k), {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
      if (k == 2) begin ack_1 = 1; md_1 = 32'h1280FF00; end
      step();
    end
    idle_inputs();
    chk("lb_stall_done", {31'd0, stall}, 32'd0);
    chk("lb_di_1", di_1, 32'hFFFFFF80);
    step();

    // Two loads acknowledged on different cycles; a repeat ack on a latched lane is ignored.
    valid_1 = 1; dest_1 = 22; m2r_1 = 1; lt_1 = 3'b000;
    valid_2 = 1; dest_2 = 23; m2r_2 = 1; lt_2 = 3'b100; off_2 = 2;
    step();
    chk("dl_stall_0", {31'd0, stall}, 32'd1);
    ack_1 = 1; md_1 = 32'h11112222;
    step();
    chk("dl_stall_1", {31'd0, stall}, 32'd1);
    md_1 = 32'hBADBAD00; ack_2 = 1; md_2 = 32'hBEEF0000;
    push(1, 1, 32'h11112222, 32'h0000BEEF, 22, 23);
    step();
    idle_inputs();
    chk("dl_stall_2", {31'd0, stall}, 32'd0);
    step();

    // Timeout: load never acknowledged, ALU lane still writes.
    valid_1 = 1; dest_1 = 16; m2r_1 = 1; lt_1 = 3'b000;
    valid_2 = 1; dest_2 = 17; alu_2 = 32'h1717;
    push(0, 1, 32'h0, 32'h1717, 16, 17);
    step();
    idle_inputs();
    n = 0;
    while (stall === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("to_stall_cycles", n, 32'd255);
    chk("to_err", {31'd0, wb_err}, 32'd1);
    chk("to_reg_wr_1", {31'd0, reg_wr_1}, 32'd1);
    chk("to_di_2", di_2, 32'h1717);
    step();
    valid_1 = 1; dest_1 = 24; alu_1 = 32'h24;
    push(1, 0, 32'h24, 32'h0, 24, 0);
    step();
    idle_inputs();
    chk("err_sticky", {31'd0, wb_err}, 32'd1);
    step();

    // Reset while stalled: immediate clear, later acknowledge writes nothing.
    valid_1 = 1; dest_1 = 18; m2r_1 = 1; lt_1 = 3'b000;
    valid_2 = 1; dest_2 = 19; alu_2 = 32'h1919;
    step();
    chk("rw_stall_before", {31'd0, stall}, 32'd1);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_reg_wr", {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
    chk("rw_di", di_1 | di_2, 32'd0);
    chk("rw_wra", {22'd0, wra_1, wra_2}, 32'd0);
    chk("rw_err", {31'd0, wb_err}, 32'd0);
    @(negedge reloj);
    reset = 1'b0;
    // First edge after reset is a normal accept; the stray ack must not revive the load.
    valid_1 = 1; dest_1 = 20; alu_1 = 32'h20; ack_1 = 1; md_1 = 32'h99999999;
    valid_2 = 1; dest_2 = 21; alu_2 = 32'h21;
    push(1, 1, 32'h20, 32'h21, 20, 21);
    step();
    chk("rr_stall", {31'd0, stall}, 32'd0);
    chk("rr_di_1", di_1, 32'h20);
    valid_1 = 0; valid_2 = 0;
    step();
    chk("rr_ack_nowrite", {30'd0, reg_wr_1, reg_wr_2}, 32'd3);
    idle_inputs();
    step();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/writeback_dual.md
WRITEBACK_DUAL -- requirements
Module: writeback_dual

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset:
- reloj  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have these per-lane inputs, with i = 1 (older lane) and i = 2 (younger lane):
- VALID_i  in  1  lane carries an instruction.
- DEST_i  in  5  destination register.
- ALU_i  in  32  ALU result.
- MEM_TO_REG_i  in  1  result comes from data memory.
- LOAD_TYPE_i  in  3  load format: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
- BYTE_OFF_i  in  2  byte address offset.
- MEM_DATA_i  in  32  memory read data.
- MEM_ACK_i  in  1  MEM_DATA_i is valid this cycle.
REQ-003 SHALL have these per-lane outputs toward the register-file write ports:
- DI_i  out  32  write data.
- DIR_WRA_i  out  5  write address.
- REG_WR_i  out  1  write enable, active-low (0 = write).
REQ-004 SHALL have these control outputs:
- STALL  out  1  upstream must hold its inputs.
- WB_ERR  out  1  sticky memory-timeout flag.
REQ-005 SHALL drive every output from a register.

Function
REQ-006 SHALL use a two-state FSM with states ACCEPT and WAIT, and assert STALL = 1 exactly when the state is WAIT.
REQ-007 In ACCEPT, when at least one lane is valid, the module SHALL sample both lanes on the edge.
- If every valid lane with MEM_TO_REG_i = 1 also has MEM_ACK_i = 1 on that edge, it SHALL register the write outputs and present them for exactly one cycle after the edge (latency 1).
- Otherwise it SHALL latch the whole pair plus any lane data already acknowledged, issue no write, and enter WAIT.
REQ-008 In WAIT, the module SHALL latch MEM_DATA_i for each still-pending lane on the edge where MEM_ACK_i = 1, and ignore MEM_ACK_i for lanes that are already latched.
REQ-009 On the edge where the last pending lane is acknowledged, the module SHALL present the writes for both lanes together in the next cycle and return to ACCEPT; the two lanes of a pair SHALL never write in different cycles.
REQ-010 Write data selection SHALL be:
- ALU_i when MEM_TO_REG_i = 0.
- Otherwise the word, byte or halfword of the memory data selected by BYTE_OFF_i, sign- or zero-extended to 32 bits per LOAD_TYPE_i.
- Halfword selection SHALL use BYTE_OFF_i[1] only.
- Reserved LOAD_TYPE_i codes (101-111) SHALL be treated as word.
REQ-011 REG_WR_i SHALL be 0 only when lane i was valid and DEST_i != 0; writes to register 0 SHALL be suppressed.
REQ-012 When both lanes are valid with DEST_1 = DEST_2 != 0, only lane 2 (the younger) SHALL write, and REG_WR_1 SHALL be 1.
REQ-013 When no write is presented, the module SHALL hold REG_WR_i = 1 and hold DI_i and DIR_WRA_i at their previous values.
REQ-014 SHALL maintain an 8-bit wait counter:
- Cleared on entering WAIT.
- Incremented on each WAIT cycle without completion.
REQ-015 When the wait counter reaches 255, the module SHALL:
- Drop the pending lane(s) with no write.
- Still write any non-load lane of the pair.
- Set WB_ERR = 1.
- Return to ACCEPT.
REQ-016 WB_ERR SHALL be cleared only by reset.
REQ-017 Inputs presented while STALL = 1 SHALL be ignored, except MEM_ACK_i and MEM_DATA_i.

Reset
REQ-018 Asserting reset SHALL immediately force the following values, even mid-WAIT, with the pending pair discarded and no write issued:
- State ACCEPT, STALL = 0.
- REG_WR_1 = REG_WR_2 = 1.
- DI_1 = DI_2 = 0, DIR_WRA_1 = DIR_WRA_2 = 0.
- Wait counter 0, WB_ERR = 0.
REQ-019 The first edge after reset deasserts SHALL be a normal ACCEPT edge.

Verification
REQ-020 The bench SHALL cover these scenarios:
- ALU pair: lane 1 {DEST 3, ALU 0x11}, lane 2 {DEST 4, ALU 0x22}, both valid -> next cycle REG_WR = 0/0, DI = 0x11/0x22, DIR_WRA = 3/4, STALL = 0.
- Collision: both DEST 5, ALU 0xA / 0xB -> REG_WR_1 = 1, REG_WR_2 = 0, DI_2 = 0xB.
- Signed byte load: lane 1 LOAD_TYPE 001, BYTE_OFF 2, MEM_DATA 0x1280FF00, MEM_ACK 0 for 3 cycles -> STALL = 1 for 3 cycles, then DI_1 = 0xFFFFFF80 with REG_WR_1 = 0; lane 2 ALU write occurs in the same cycle.
- DEST 0 with valid ALU lane -> REG_WR stays 1.
- Timeout: load with MEM_ACK held at 0 -> after 255 WAIT cycles WB_ERR = 1, no write for the load lane, STALL returns to 0.
- Reset asserted during WAIT -> STALL = 0 and REG_WR = 1/1 immediately; a later MEM_ACK causes no write.
